// File: rtl/sd_spi_responder_pkg.sv
// rtl/sd_spi_responder_pkg.sv - shared types, constants and CRC7 helper for the SD SPI responder
package sd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    CMD,
    WAIT_RESP,
    SEND_R1
  } state_t;

  localparam logic [7:0] R1_CRC_ERR = 8'h08;
  localparam logic [1:0] START_MASK = 2'b01;
  localparam logic [6:0] CRC7_POLY  = 7'h09;

  // MSB-first CRC7 update, x^7 + x^3 + 1
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ CRC7_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_spi_responder_if.sv
// rtl/sd_spi_responder_if.sv - SPI pins plus local command/response signals of the SD responder
interface sd_spi_responder_if;
  logic        spi_sclk;
  logic        spi_ss_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_valid;
  logic [7:0]  resp_r1;
  logic        crc_err;
  logic        resp_timeout;

  modport slave (
    input  spi_sclk, spi_ss_n, spi_mosi, resp_valid, resp_r1,
    output spi_miso, spi_miso_oe, cmd_valid, cmd_index, cmd_arg, crc_err, resp_timeout
  );

  modport master (
    output spi_sclk, spi_ss_n, spi_mosi, resp_valid, resp_r1,
    input  spi_miso, spi_miso_oe, cmd_valid, cmd_index, cmd_arg, crc_err, resp_timeout
  );
endinterface

// File: rtl/sd_spi_responder_pin_sync.sv
// rtl/sd_spi_responder_pin_sync.sv - SPI pin synchronisers with SCLK and SS_N edge pulses
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_ss_n,
  output logic o_ss_fall,
  output logic o_mosi
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;
  logic                   w_sclk;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '1;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= o_ss_n;
    end
  end

  // MOSI shares the SCLK pipeline depth, so the rise pulse lines up with its bit
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign o_ss_n      = r_ss_sync[SYNC_STAGES-1];
  assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign o_sclk_rise = w_sclk & ~r_sclk_d;
  assign o_sclk_fall = ~w_sclk & r_sclk_d;
  assign o_ss_fall   = ~o_ss_n & r_ss_d;

endmodule

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SD card SPI-mode command framer and R1 responder
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit CRC_CHECK   = 1'b1,
  parameter int NCR_MAX     = 8
) (
  input  logic              i_pclk,
  input  logic              i_preset,
  sd_spi_responder_if.slave bus
);

  logic        w_sclk_rise, w_sclk_fall, w_ss_n, w_ss_fall, w_mosi;
  logic [7:0]  w_rx_byte, w_tx_next;
  logic [6:0]  w_crc_next;
  logic        w_byte_done, w_crc_ok;

  state_t      r_state;
  logic [2:0]  r_bit_cnt, r_byte_cnt;
  logic [6:0]  r_rx, r_crc;
  logic [7:0]  r_tx, r_r1, r_fill_cnt;
  logic        r_miso, r_oe, r_have_r1;
  logic [5:0]  r_idx_sh, r_cmd_index;
  logic [31:0] r_arg_sh, r_cmd_arg;
  logic        r_cmd_valid, r_crc_err, r_timeout;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk       (i_pclk),
    .i_rst       (i_preset),
    .i_sclk      (bus.spi_sclk),
    .i_ss_n      (bus.spi_ss_n),
    .i_mosi      (bus.spi_mosi),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_ss_n      (w_ss_n),
    .o_ss_fall   (w_ss_fall),
    .o_mosi      (w_mosi)
  );

  assign w_rx_byte   = {r_rx, w_mosi};
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
  assign w_crc_next  = crc7_byte(r_crc, w_rx_byte);
  assign w_crc_ok    = (w_rx_byte[7:1] == r_crc) && w_rx_byte[0];
  assign w_tx_next   = (r_state == SEND_R1) ? r_r1 : 8'hFF;

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_rx        <= '0;
      r_crc       <= '0;
      r_tx        <= 8'hFF;
      r_r1        <= 8'hFF;
      r_fill_cnt  <= '0;
      r_miso      <= 1'b1;
      r_oe        <= 1'b0;
      r_have_r1   <= 1'b0;
      r_idx_sh    <= '0;
      r_arg_sh    <= '0;
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_cmd_valid <= 1'b0;
      r_crc_err   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_crc_err   <= 1'b0;
      r_timeout   <= 1'b0;
      r_oe        <= ~w_ss_n;
      // Deselect has priority over any byte boundary seen in the same cycle
      if (w_ss_n) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b1;
        r_tx      <= 8'hFF;
        r_have_r1 <= 1'b0;
      end else if (w_ss_fall) begin
        r_state   <= HUNT;
        r_bit_cnt <= '0;
        r_miso    <= 1'b1;
        r_tx      <= 8'hFF;
        r_have_r1 <= 1'b0;
      end else if (r_state != IDLE) begin
        if (w_sclk_fall) begin
          if (r_bit_cnt == 3'd0) begin
            r_miso <= w_tx_next[7];
            r_tx   <= {w_tx_next[6:0], 1'b1};
          end else begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b1};
          end
        end
        if (w_sclk_rise) begin
          r_rx      <= w_rx_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (r_state == WAIT_RESP && bus.resp_valid && !r_have_r1) begin
          r_have_r1 <= 1'b1;
          r_r1      <= bus.resp_r1;
        end
        if (w_byte_done) begin
          case (r_state)
            HUNT: if (w_rx_byte[7:6] == START_MASK) begin
              r_state    <= CMD;
              r_idx_sh   <= w_rx_byte[5:0];
              r_crc      <= crc7_byte(7'd0, w_rx_byte);
              r_byte_cnt <= 3'd1;
            end
            CMD: if (r_byte_cnt != 3'd5) begin
              r_arg_sh   <= {r_arg_sh[23:0], w_rx_byte};
              r_crc      <= w_crc_next;
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end else if (w_crc_ok || !CRC_CHECK) begin
              r_cmd_valid <= 1'b1;
              r_cmd_index <= r_idx_sh;
              r_cmd_arg   <= r_arg_sh;
              r_have_r1   <= 1'b0;
              r_fill_cnt  <= '0;
              r_state     <= WAIT_RESP;
            end else begin
              r_crc_err <= 1'b1;
              r_r1      <= R1_CRC_ERR;
              r_state   <= SEND_R1;
            end
            WAIT_RESP: if (r_have_r1) begin
              r_state <= SEND_R1;
            end else if (r_fill_cnt == 8'(NCR_MAX - 1)) begin
              r_timeout <= 1'b1;
              r_state   <= HUNT;
            end else begin
              r_fill_cnt <= r_fill_cnt + 8'd1;
            end
            SEND_R1: r_state <= HUNT;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.spi_miso     = r_miso;
  assign bus.spi_miso_oe  = r_oe;
  assign bus.cmd_valid    = r_cmd_valid;
  assign bus.cmd_index    = r_cmd_index;
  assign bus.cmd_arg      = r_cmd_arg;
  assign bus.crc_err      = r_crc_err;
  assign bus.resp_timeout = r_timeout;

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - scoreboard bench for the SD SPI responder
module tb_sd_spi_responder;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  sd_spi_responder_if bus();

  sd_spi_responder #(.SYNC_STAGES(2), .CRC_CHECK(1'b1), .NCR_MAX(8)) dut (
    .i_pclk   (pclk),
    .i_preset (preset),
    .bus      (bus)
  );

  typedef struct {logic [5:0] idx; logic [31:0] arg;} cmd_t;
  typedef struct {bit en; int dly; logic [7:0] r1;} plan_t;

  int          errors = 0;
  int          checks = 0;
  cmd_t        exp_cmd[$];
  plan_t       plans[$];
  logic [7:0]  exp_miso[$];
  int          exp_crc = 0;
  int          exp_to = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_mosi = b[i];
      repeat (8) @(negedge pclk);
      bus.spi_sclk = 1'b1;
      repeat (8) @(negedge pclk);
      bus.spi_sclk = 1'b0;
    end
    repeat (16) @(negedge pclk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] rx);
    exp_miso.push_back(rx);
    spi_bits(tx, 8);
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int k = 0; k < 6; k++) spi_byte(f[47-8*k -: 8], 8'hFF);
  endtask

  task automatic select(input string name);
    bus.spi_ss_n = 1'b0;
    repeat (16) @(negedge pclk);
    check({name, "_oe_on"}, bus.spi_miso_oe, 1'b1);
  endtask

  task automatic deselect(input string name);
    bus.spi_ss_n = 1'b1;
    repeat (16) @(negedge pclk);
    check({name, "_oe_off"}, bus.spi_miso_oe, 1'b0);
  endtask

  task automatic reset_checks(input string name);
    check({name, "_miso"}, bus.spi_miso, 1'b1);
    check({name, "_oe"}, bus.spi_miso_oe, 1'b0);
    check({name, "_cmd_valid"}, bus.cmd_valid, 1'b0);
    check({name, "_cmd_index"}, bus.cmd_index, 6'd0);
    check({name, "_cmd_arg"}, bus.cmd_arg, 32'd0);
    check({name, "_crc_err"}, bus.crc_err, 1'b0);
    check({name, "_timeout"}, bus.resp_timeout, 1'b0);
  endtask

  // MISO byte monitor: master samples on SCLK rise
  initial begin
    logic [7:0] sh;
    int         n;
    sh = 8'h00;
    n  = 0;
    forever begin
      @(posedge bus.spi_sclk or posedge bus.spi_ss_n);
      if (bus.spi_ss_n) n = 0;
      else begin
        sh = {sh[6:0], bus.spi_miso};
        n++;
        if (n == 8) begin
          n = 0;
          if (exp_miso.size() == 0) begin
            checks++; errors++;
            $display("FAIL miso_unexpected: got %0h expected no byte", sh);
          end else check("miso_byte", sh, exp_miso.pop_front());
        end
      end
    end
  end

  // Pulse monitor
  initial begin
    cmd_t e;
    forever begin
      @(negedge pclk);
      if (bus.cmd_valid) begin
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_valid_unexpected: got index %0h expected no pulse", bus.cmd_index);
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_index", bus.cmd_index, e.idx);
          check("cmd_arg", bus.cmd_arg, e.arg);
        end
      end
      if (bus.crc_err) begin
        checks++;
        if (exp_crc == 0) begin
          errors++;
          $display("FAIL crc_err_unexpected: got pulse expected none");
        end else exp_crc--;
      end
      if (bus.resp_timeout) begin
        checks++;
        if (exp_to == 0) begin
          errors++;
          $display("FAIL timeout_unexpected: got pulse expected none");
        end else exp_to--;
      end
    end
  end

  // Local logic model supplying R1 after a planned delay
  initial begin
    plan_t p;
    forever begin
      @(negedge pclk);
      if (bus.cmd_valid && plans.size() != 0) begin
        p = plans.pop_front();
        if (p.en) begin
          repeat (p.dly) @(negedge pclk);
          bus.resp_valid = 1'b1;
          bus.resp_r1    = p.r1;
          @(negedge pclk);
          bus.resp_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.spi_sclk   = 1'b0;
    bus.spi_ss_n   = 1'b1;
    bus.spi_mosi   = 1'b1;
    bus.resp_valid = 1'b0;
    bus.resp_r1    = 8'h00;
    repeat (3) @(negedge pclk);
    reset_checks("rst0");
    preset = 1'b0;
    repeat (4) @(negedge pclk);

    // CMD0, R1 three cycles after CMD_VALID
    exp_cmd.push_back('{6'd0, 32'd0});
    plans.push_back('{1'b1, 3, 8'h01});
    select("cmd0");
    send_frame(48'h40_00_00_00_00_95);
    spi_byte(8'hFF, 8'hFF);
    spi_byte(8'hFF, 8'h01);
    deselect("cmd0");

    // CMD8, R1 late enough for three fillers
    exp_cmd.push_back('{6'd8, 32'h0000_01AA});
    plans.push_back('{1'b1, 350, 8'h01});
    select("cmd8");
    send_frame(48'h48_00_00_01_AA_87);
    spi_byte(8'hFF, 8'hFF);
    spi_byte(8'hFF, 8'hFF);
    spi_byte(8'hFF, 8'hFF);
    spi_byte(8'hFF, 8'h01);
    deselect("cmd8");

    // Reset in the middle of frame byte 3
    select("rstmid");
    spi_byte(8'h40, 8'hFF);
    spi_byte(8'h00, 8'hFF);
    spi_byte(8'h00, 8'hFF);
    spi_bits(8'h00, 4);
    preset = 1'b1;
    @(negedge pclk);
    reset_checks("rst_mid");
    preset = 1'b0;
    repeat (4) @(negedge pclk);
    deselect("rstmid");
    exp_cmd.push_back('{6'd0, 32'd0});
    plans.push_back('{1'b1, 3, 8'h01});
    select("postrst");
    send_frame(48'h40_00_00_00_00_95);
    spi_byte(8'hFF, 8'hFF);
    spi_byte(8'hFF, 8'h01);
    deselect("postrst");

    // CMD17 with no response: eight fillers then timeout, then CMD0 in same selection
    exp_cmd.push_back('{6'd17, 32'd0});
    plans.push_back('{1'b0, 0, 8'h00});
    exp_to++;
    select("cmd17");
    send_frame(48'h51_00_00_00_00_55);
    for (int i = 0; i < 8; i++) spi_byte(8'hFF, 8'hFF);
    exp_cmd.push_back('{6'd0, 32'd0});
    plans.push_back('{1'b1, 3, 8'h01});
    send_frame(48'h40_00_00_00_00_95);
    spi_byte(8'hFF, 8'hFF);
    spi_byte(8'hFF, 8'h01);
    deselect("cmd17");

    // Bad CRC
    exp_crc++;
    select("crcerr");
    send_frame(48'h40_00_00_00_00_97);
    spi_byte(8'hFF, 8'h08);
    deselect("crcerr");

    // Aborted partial frame followed by a full CMD0
    select("partial");
    spi_byte(8'h40, 8'hFF);
    spi_byte(8'h00, 8'hFF);
    spi_byte(8'h00, 8'hFF);
    deselect("partial");
    exp_cmd.push_back('{6'd0, 32'd0});
    plans.push_back('{1'b1, 3, 8'h01});
    select("full");
    send_frame(48'h40_00_00_00_00_95);
    spi_byte(8'hFF, 8'hFF);
    spi_byte(8'hFF, 8'h01);
    deselect("full");

    repeat (50) @(negedge pclk);
    check("cmd_pending", exp_cmd.size(), 0);
    check("miso_pending", exp_miso.size(), 0);
    check("crc_pending", exp_crc, 0);
    check("timeout_pending", exp_to, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
